// File: rtl/r30_sequencer.sv
// Rule 30 CA sequencer: owns the CA state register, steps an external combinational
// array once per clock and packs the tap-cell bitstream into W-bit output words.
module r30_sequencer #(
  parameter int unsigned N     = 128,
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TAP   = N / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [N-1:0]     seed_data,
  input  logic             start,
  input  logic [CNT_W-1:0] gen_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [W-1:0]     word_data,
  output logic [N-1:0]     arr_state_in,
  input  logic [N-1:0]     arr_state_out
);

  localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     s_q, s_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic             word_valid_q, word_valid_d;
  logic [W-1:0]     word_data_q, word_data_d;
  logic             done_q, done_d;

  logic             tap_bit;
  logic             word_full;
  logic             stall;
  logic [W-1:0]     acc_with_bit;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    count_d      = count_q;
    acc_d        = acc_q;
    k_d          = k_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    done_d       = 1'b0;

    tap_bit      = arr_state_out[TAP];
    word_full    = (k_q == KW'(W - 1));
    stall        = word_full && word_valid_q && !word_ready;
    // acc bits at and above k are always zero, so OR-ing the new bit in place
    // yields {b, acc[W-2:0]} when the word completes.
    acc_with_bit = acc_q | (W'(tap_bit) << k_q);

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (seed_valid) begin
          s_d = seed_data;
        end
        if (start) begin
          count_d = gen_count;
          if (gen_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (!stall) begin
          s_d     = arr_state_out;
          count_d = count_q - CNT_W'(1);
          if (word_full) begin
            word_data_d  = acc_with_bit;
            word_valid_d = 1'b1;
            acc_d        = '0;
            k_d          = '0;
          end else begin
            acc_d = acc_with_bit;
            k_d   = k_q + KW'(1);
          end
          if (count_q == CNT_W'(1)) begin
            state_d = word_full ? DRAIN : FLUSH;
          end
        end
      end

      FLUSH: begin
        if (!word_valid_q || word_ready) begin
          word_data_d  = acc_q;
          word_valid_d = 1'b1;
          acc_d        = '0;
          k_d          = '0;
          state_d      = DRAIN;
        end
      end

      DRAIN: begin
        if (!word_valid_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the active state decided, including an advance.
    if (abort && state_q != IDLE) begin
      state_d      = IDLE;
      s_d          = s_q;
      count_d      = '0;
      acc_d        = '0;
      k_d          = '0;
      word_valid_d = 1'b0;
      word_data_d  = word_data_q;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      count_q      <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      done_q       <= done_d;
    end
  end

  assign seed_ready   = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign word_valid   = word_valid_q;
  assign word_data    = word_data_q;
  assign arr_state_in = s_q;

endmodule
